digit_poly_transposer: RTL and testbench
========================================

// Module: digit_poly_transposer
// PURPOSE
//  Sits directly downstream of the signed-digit decomposer in the FHEW accumulator path.
//  Takes one decomposed coefficient per beat (all DIGITS signed digits of coefficient i).
//  Re-emits the frame digit-major (digit 0 for all N coeffs, then digit 1, ...) for the forward NTT.
//  Double-buffers frames in ping-pong banks and lifts each signed digit into [0,Q).
// PARAMETERS
//  N        1024       ring dimension (coefficients per polynomial), power of two
//  DIGITS   4          signed digits per coefficient (decomposition length)
//  DIGIT_W  8          width of one two's-complement signed digit
//  Q_W      27         width of output residue
//  Q        134215681  NTT modulus; digits lifted mod Q
// PORTS
//  clk            in   1                clock, rising edge
//  rst            in   1                reset, asynchronous, active-high
//  in_valid       in   1                in_digits holds a valid coefficient
//  in_ready       out  1                transposer accepts a beat this cycle
//  in_digits      in   DIGITS*DIGIT_W   signed digits; digit j at [j*DIGIT_W +: DIGIT_W]
//  out_valid      out  1                out_data valid
//  out_ready      in   1                NTT accepts out_data this cycle
//  out_data       out  Q_W              lifted digit, 0 <= out_data < Q
//  out_digit_idx  out  $clog2(DIGITS)   digit index j of current word
//  out_coef_idx   out  $clog2(N)        coefficient index i of current word
//  out_poly_last  out  1                high with i==N-1 (last word of digit polynomial j)
//  out_frame_last out  1                high with i==N-1 && j==DIGITS-1
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - Both banks go to EMPTY.
//   - wr_sel=rd_sel=0; all counters 0.
//   - out_valid=0, in_ready=1, out_data/idx/last outputs 0.
//  Handshakes:
//   - Transfer occurs when valid&&ready.
//   - While out_valid=1 && out_ready=0: out_data, indices and last flags held stable.
//   - in_ready has no combinational dependence on in_valid.
//  Per-bank FSM: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
//   - EMPTY->FILLING: on the first accepted input beat.
//   - FILLING->FULL: on the Nth accepted beat; wr_sel then toggles.
//   - FULL->DRAINING: when rd_sel points at the bank and the read pipe is free.
//   - DRAINING->EMPTY: on the cycle the word (j=DIGITS-1, i=N-1) is issued to the read pipe;
//     rd_sel then toggles.
//  in_ready = (bank[wr_sel] is EMPTY or FILLING).
//   - Both banks FULL/DRAINING -> in_ready=0.
//  Write: accepted beat i stores the whole digit vector at bank[wr_sel][i]; i wraps N-1 -> 0.
//  Read order: j outer 0..DIGITS-1, i inner 0..N-1; i wraps to 0 and j increments.
//  Latency:
//   - Memory read registered (1 cycle) plus output register.
//   - First out_valid exactly 2 cycles after the Nth input beat, if the other bank is idle.
//  Throughput: with out_ready=1, one word per cycle, no bubbles between polys or between frames.
//  Lift: d = selected digit (signed); out_data = (d<0) ? Q+d : d, computed in Q_W+1 bits.
//   - d=0 -> 0.
//   - Most-negative digit -2^(DIGIT_W-1) -> Q-2^(DIGIT_W-1).
//  Simultaneous events:
//   - A bank can finish FILLING while the other finishes DRAINING in the same cycle.
//     Both transitions take effect, and the newly FULL bank starts draining next cycle.
//   - Input accept and output issue in the same cycle are independent.
//  Reset mid-frame: partial input and undrained words are discarded; no output after release
//   until a new full frame arrives.
// TESTING (bench: N=8, DIGITS=3, DIGIT_W=8, Q=97)
//  1. Reset values: assert rst mid-cycle -> out_valid=0 and in_ready=1 immediately.
//     Release, then 8 beats with digits(i,j)=i+10j -> out_data sequence 0..7,10..17,20..27.
//     Check out_poly_last at words 7/15/23, out_frame_last only at word 23,
//     first out_valid 2 cycles after beat 8.
//  2. Negative lift: digit -1 -> 96; -128 -> 97-128 mod 97 = 66; +127 -> 127 mod 97 = 30.
//     Width check: the lifted value must be < Q and equals Q+d for negative d within range.
//     Use |d|<=Q in the bench.
//  3. Ping-pong: stream 3 frames back-to-back with out_ready=1.
//     -> in_ready drops after frame 2 fills, rises the cycle frame 1's last word issues.
//     -> Output is 72 contiguous words with no gaps.
//  4. Backpressure: out_ready toggles 1,0,0,1 randomly.
//     -> Each word is delivered exactly once, in order, and held stable while stalled.
//  5. Mid-frame reset: reset after 5 input beats and after 10 output words.
//     -> No further out_valid.
//     -> The next full frame is emitted from i=0, j=0 with correct data.

Source files
------------

// File: rtl/digit_poly_transposer_if.sv
// Stream bundle for the digit polynomial transposer.
// Input coefficient beats and output lifted digit words.
interface digit_poly_transposer_if #(
    parameter int N       = 1024,
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 8,
    parameter int Q_W     = 27
);
    localparam int CW = $clog2(N);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                      in_valid;
    logic                      in_ready;
    logic [DIGITS*DIGIT_W-1:0] in_digits;
    logic                      out_valid;
    logic                      out_ready;
    logic [Q_W-1:0]            out_data;
    logic [DW-1:0]             out_digit_idx;
    logic [CW-1:0]             out_coef_idx;
    logic                      out_poly_last;
    logic                      out_frame_last;

    modport master (
        output in_valid, in_digits, out_ready,
        input  in_ready, out_valid, out_data, out_digit_idx,
        input  out_coef_idx, out_poly_last, out_frame_last
    );

    modport slave (
        input  in_valid, in_digits, out_ready,
        output in_ready, out_valid, out_data, out_digit_idx,
        output out_coef_idx, out_poly_last, out_frame_last
    );
endinterface

// File: rtl/digit_poly_transposer.sv
// Ping-pong transposer: coefficient-major in, digit-major out.
// Each signed digit is lifted into [0,Q) on the way out.
module digit_poly_transposer #(
    parameter int N       = 1024,
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 8,
    parameter int Q_W     = 27,
    parameter int Q       = 134215681
) (
    input logic clk,
    input logic rst,
    digit_poly_transposer_if.slave bus
);
    localparam int CW = $clog2(N);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = DIGITS * DIGIT_W;
    localparam int LW = ((Q_W > DIGIT_W) ? Q_W : DIGIT_W) + 2;
    localparam logic signed [LW-1:0] QS = LW'(Q);

    typedef enum logic [1:0] {
        ST_EMPTY, ST_FILLING, ST_FULL, ST_DRAINING
    } bank_st_e;

    bank_st_e st_q [2];
    bank_st_e st_d [2];

    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_i_q, rd_i_d;
    logic [DW-1:0] rd_j_q, rd_j_d;

    logic [VW-1:0] mem [2*N];

    logic          s1_v_q;
    logic [VW-1:0] s1_vec_q;
    logic [DW-1:0] s1_j_q;
    logic [CW-1:0] s1_i_q;
    logic          s1_pl_q, s1_fl_q;

    logic           out_v_q;
    logic [Q_W-1:0] out_data_q;
    logic [DW-1:0]  out_j_q;
    logic [CW-1:0]  out_i_q;
    logic           out_pl_q, out_fl_q;

    logic in_ready, accept, adv2, pipe_free, issue, rd_last;
    logic signed [DIGIT_W-1:0] dig;
    logic signed [LW-1:0]      lift;
    logic                      lift_unused;

    // Bank state, write/read pointers and counters: next-state logic.
    always_comb begin
        st_d[0]  = st_q[0];
        st_d[1]  = st_q[1];
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        wr_cnt_d = wr_cnt_q;
        rd_i_d   = rd_i_q;
        rd_j_d   = rd_j_q;
        in_ready = (st_q[wr_sel_q] == ST_EMPTY) ||
                   (st_q[wr_sel_q] == ST_FILLING);
        accept    = bus.in_valid && in_ready;
        adv2      = !out_v_q || bus.out_ready;
        pipe_free = !s1_v_q || adv2;
        issue     = pipe_free &&
                    ((st_q[rd_sel_q] == ST_FULL) ||
                     (st_q[rd_sel_q] == ST_DRAINING));
        rd_last   = (rd_j_q == DW'(DIGITS - 1)) &&
                    (rd_i_q == CW'(N - 1));
        if (accept) begin
            wr_cnt_d = wr_cnt_q + CW'(1);
            if (wr_cnt_q == CW'(N - 1)) begin
                st_d[wr_sel_q] = ST_FULL;
                wr_sel_d       = ~wr_sel_q;
            end else begin
                st_d[wr_sel_q] = ST_FILLING;
            end
        end
        if (issue) begin
            if (rd_last) begin
                st_d[rd_sel_q] = ST_EMPTY;
                rd_sel_d       = ~rd_sel_q;
                rd_i_d         = '0;
                rd_j_d         = '0;
            end else begin
                st_d[rd_sel_q] = ST_DRAINING;
                rd_i_d         = rd_i_q + CW'(1);
                if (rd_i_q == CW'(N - 1)) begin
                    rd_j_d = rd_j_q + DW'(1);
                end
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q[0]  <= ST_EMPTY;
            st_q[1]  <= ST_EMPTY;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_cnt_q <= '0;
            rd_i_q   <= '0;
            rd_j_q   <= '0;
        end else begin
            st_q[0]  <= st_d[0];
            st_q[1]  <= st_d[1];
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wr_cnt_q <= wr_cnt_d;
            rd_i_q   <= rd_i_d;
            rd_j_q   <= rd_j_d;
        end
    end

    // Bank storage: whole digit vector written, registered read.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[{wr_sel_q, wr_cnt_q}] <= bus.in_digits;
        end
        if (issue) begin
            s1_vec_q <= mem[{rd_sel_q, rd_i_q}];
        end
    end

    // Read-stage tag registers travelling with the memory data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q  <= 1'b0;
            s1_j_q  <= '0;
            s1_i_q  <= '0;
            s1_pl_q <= 1'b0;
            s1_fl_q <= 1'b0;
        end else if (pipe_free) begin
            s1_v_q <= issue;
            if (issue) begin
                s1_j_q  <= rd_j_q;
                s1_i_q  <= rd_i_q;
                s1_pl_q <= (rd_i_q == CW'(N - 1));
                s1_fl_q <= rd_last;
            end
        end
    end

    // Select digit j and fold it into [0,Q).
    always_comb begin
        dig  = s1_vec_q[32'(s1_j_q)*DIGIT_W +: DIGIT_W];
        lift = LW'(dig);
        if (lift < 0) begin
            lift = lift + QS;
        end
        if (lift < 0) begin
            lift = lift + QS;
        end
        if (lift >= QS) begin
            lift = lift - QS;
        end
        lift_unused = ^lift[LW-1:Q_W];
    end

    // Output register, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_v_q    <= 1'b0;
            out_data_q <= '0;
            out_j_q    <= '0;
            out_i_q    <= '0;
            out_pl_q   <= 1'b0;
            out_fl_q   <= 1'b0;
        end else if (adv2) begin
            out_v_q <= s1_v_q;
            if (s1_v_q) begin
                out_data_q <= lift[Q_W-1:0];
                out_j_q    <= s1_j_q;
                out_i_q    <= s1_i_q;
                out_pl_q   <= s1_pl_q;
                out_fl_q   <= s1_fl_q;
            end
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_v_q;
    assign bus.out_data       = out_data_q;
    assign bus.out_digit_idx  = out_j_q;
    assign bus.out_coef_idx   = out_i_q;
    assign bus.out_poly_last  = out_pl_q;
    assign bus.out_frame_last = out_fl_q;
endmodule

// File: tb/tb_digit_poly_transposer.sv
// Bench for digit_poly_transposer: scoreboard of expected
// lifted words checked in order at the output handshake.
module tb_digit_poly_transposer;
    localparam int N       = 8;
    localparam int DIGITS  = 3;
    localparam int DIGIT_W = 8;
    localparam int Q_W     = 7;
    localparam int QM      = 97;
    localparam int VW      = DIGITS * DIGIT_W;

    typedef struct {
        logic [Q_W-1:0] data;
        int             j;
        int             i;
        bit             pl;
        bit             fl;
    } exp_t;

    logic clk;
    logic rst;

    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   out_cnt    = 0;
    int   last_acc_cyc = 0;
    bit   mon_en     = 0;
    bit   stall_q    = 0;
    exp_t sb [$];
    exp_t e;
    int   frame_d [N][DIGITS];
    int   neg_tab [8] = '{-1, -128, 127, 0, -97, 97, 96, -50};

    logic [Q_W-1:0] h_data;
    logic [1:0]     h_j;
    logic [2:0]     h_i;
    logic           h_pl, h_fl;

    digit_poly_transposer_if #(
        .N(N), .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .Q_W(Q_W)
    ) bus ();

    digit_poly_transposer #(
        .N(N), .DIGITS(DIGITS), .DIGIT_W(DIGIT_W),
        .Q_W(Q_W), .Q(QM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic int lift_model(input int d);
        int r;
        r = d % QM;
        if (r < 0) r = r + QM;
        return r;
    endfunction

    // Output monitor: pops the scoreboard on every transfer and
    // checks that a stalled word is held unchanged.
    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_q) begin
                vectors++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== h_data ||
                    bus.out_digit_idx !== h_j || bus.out_coef_idx !== h_i ||
                    bus.out_poly_last !== h_pl || bus.out_frame_last !== h_fl) begin
                    miscompares++;
                    $display("FAIL hold: got v=%0b d=%0d j=%0d i=%0d want v=1 d=%0d j=%0d i=%0d",
                             bus.out_valid, bus.out_data, bus.out_digit_idx,
                             bus.out_coef_idx, h_data, h_j, h_i);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word: got d=%0d j=%0d i=%0d want none",
                             bus.out_data, bus.out_digit_idx, bus.out_coef_idx);
                end else begin
                    e = sb.pop_front();
                    out_cnt++;
                    if (bus.out_data !== e.data ||
                        int'(bus.out_digit_idx) !== e.j ||
                        int'(bus.out_coef_idx) !== e.i ||
                        bus.out_poly_last !== e.pl ||
                        bus.out_frame_last !== e.fl) begin
                        miscompares++;
                        $display("FAIL word: got d=%0d j=%0d i=%0d pl=%0b fl=%0b want d=%0d j=%0d i=%0d pl=%0b fl=%0b",
                                 bus.out_data, bus.out_digit_idx, bus.out_coef_idx,
                                 bus.out_poly_last, bus.out_frame_last,
                                 e.data, e.j, e.i, e.pl, e.fl);
                    end
                end
            end
            stall_q = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
            h_data  = bus.out_data;
            h_j     = bus.out_digit_idx;
            h_i     = bus.out_coef_idx;
            h_pl    = bus.out_poly_last;
            h_fl    = bus.out_frame_last;
        end
    end

    // mode 0: i+10j, mode 1: lift corner table, else random.
    task automatic send_frame(input int mode, input int nbeats, output bit ok);
        logic [VW-1:0] v;
        bit acc;
        int t;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < DIGITS; j++) begin
                if (mode == 0) frame_d[i][j] = i + 10 * j;
                else if (mode == 1) frame_d[i][j] = neg_tab[(i * DIGITS + j) % 8];
                else frame_d[i][j] = int'($urandom_range(0, 2 * QM)) - QM;
            end
        end
        ok = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            for (int j = 0; j < DIGITS; j++) begin
                v[j*DIGIT_W +: DIGIT_W] = DIGIT_W'(frame_d[i][j]);
            end
            bus.in_valid  = 1'b1;
            bus.in_digits = v;
            acc = 1'b0;
            t = 0;
            while (!acc && t < 300) begin
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk);
                #1;
                t++;
            end
            bus.in_valid = 1'b0;
            if (!acc) begin
                vectors++;
                miscompares++;
                $display("FAIL in_accept: got in_ready=0 for %0d cycles want accept", t);
                ok = 1'b0;
                return;
            end
        end
        last_acc_cyc = cyc;
        if (nbeats == N) begin
            for (int j = 0; j < DIGITS; j++) begin
                for (int i = 0; i < N; i++) begin
                    sb.push_back('{data: Q_W'(lift_model(frame_d[i][j])),
                                   j: j, i: i, pl: (i == N - 1),
                                   fl: (i == N - 1 && j == DIGITS - 1)});
                end
            end
        end
    endtask

    task automatic wait_empty(input int limit);
        int t = 0;
        while (sb.size() != 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_digits = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_hs: got out_valid=%0b in_ready=%0b want 0 1",
                     bus.out_valid, bus.in_ready);
        end
        vectors++;
        if (bus.out_data !== '0 || bus.out_digit_idx !== '0 ||
            bus.out_coef_idx !== '0 || bus.out_poly_last !== 1'b0 ||
            bus.out_frame_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out: got d=%0d j=%0d i=%0d pl=%0b fl=%0b want all 0",
                     bus.out_data, bus.out_digit_idx, bus.out_coef_idx,
                     bus.out_poly_last, bus.out_frame_last);
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        int t = 0;
        int c0 = out_cnt;
        send_frame(0, N, ok);
        do begin
            @(negedge clk);
            t++;
        end while (bus.out_valid !== 1'b1 && t < 20);
        vectors++;
        if (cyc - last_acc_cyc !== 2) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles want 2", cyc - last_acc_cyc);
        end
        wait_empty(200);
        vectors++;
        if (out_cnt - c0 !== N * DIGITS) begin
            miscompares++;
            $display("FAIL basic_count: got %0d words want %0d", out_cnt - c0, N * DIGITS);
        end
    endtask

    task automatic test_neg_lift();
        bit ok;
        int c0 = out_cnt;
        send_frame(1, N, ok);
        wait_empty(200);
        vectors++;
        if (out_cnt - c0 !== N * DIGITS) begin
            miscompares++;
            $display("FAIL lift_count: got %0d words want %0d", out_cnt - c0, N * DIGITS);
        end
    endtask

    task automatic test_ping_pong();
        int first = -1, last = -1, nvalid = 0;
        int drop = -1, rise = -1, flc = -1, f2done = -1;
        int t = 0;
        bit ok;
        bus.out_ready = 1'b1;
        fork
            begin
                send_frame(2, N, ok);
                send_frame(2, N, ok);
                f2done = cyc;
                send_frame(2, N, ok);
            end
            begin
                while (nvalid < 3 * N * DIGITS && t < 500) begin
                    @(negedge clk);
                    t++;
                    if (bus.out_valid === 1'b1) begin
                        if (first < 0) first = cyc;
                        last = cyc;
                        nvalid++;
                        if (bus.out_frame_last === 1'b1 && flc < 0) flc = cyc;
                    end
                    if (bus.in_ready === 1'b0 && drop < 0) drop = cyc;
                    if (bus.in_ready === 1'b1 && drop >= 0 && rise < 0) rise = cyc;
                end
            end
        join
        wait_empty(200);
        vectors++;
        if (nvalid !== 72 || last - first + 1 !== 72) begin
            miscompares++;
            $display("FAIL pp_contig: got %0d words over %0d cycles want 72 over 72",
                     nvalid, last - first + 1);
        end
        vectors++;
        if (drop !== f2done) begin
            miscompares++;
            $display("FAIL pp_drop: got cycle %0d want %0d", drop, f2done);
        end
        vectors++;
        if (rise !== flc - 1) begin
            miscompares++;
            $display("FAIL pp_rise: got cycle %0d want %0d", rise, flc - 1);
        end
    endtask

    task automatic test_backpressure();
        bit stop = 1'b0;
        bit ok;
        int c0 = out_cnt;
        int pat [4] = '{1, 0, 0, 1};
        fork
            begin
                int k = 0;
                while (!stop) begin
                    if (k < 4) bus.out_ready = 1'(pat[k]);
                    else bus.out_ready = 1'($urandom_range(0, 1));
                    k++;
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
            begin
                send_frame(2, N, ok);
                send_frame(2, N, ok);
                wait_empty(3000);
                stop = 1'b1;
            end
        join
        wait_empty(200);
        vectors++;
        if (sb.size() !== 0 || out_cnt - c0 !== 2 * N * DIGITS) begin
            miscompares++;
            $display("FAIL bp_count: got %0d words %0d pending want %0d 0",
                     out_cnt - c0, sb.size(), 2 * N * DIGITS);
        end
    endtask

    task automatic test_midframe_reset();
        bit ok;
        int t = 0;
        int nv = 0;
        int c0;
        bus.out_ready = 1'b1;
        send_frame(2, 5, ok);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_partial: got out_valid=%0b in_ready=%0b want 0 1",
                     bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        c0 = out_cnt;
        send_frame(2, N, ok);
        while (out_cnt - c0 < 10 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        mon_en = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_drain: got out_valid=%0b in_ready=%0b want 0 1",
                     bus.out_valid, bus.in_ready);
        end
        sb.delete();
        stall_q = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) nv++;
        end
        vectors++;
        if (nv !== 0) begin
            miscompares++;
            $display("FAIL rst_quiet: got %0d valid cycles want 0", nv);
        end
        @(posedge clk);
        #1;
        c0 = out_cnt;
        send_frame(0, N, ok);
        wait_empty(200);
        vectors++;
        if (out_cnt - c0 !== N * DIGITS) begin
            miscompares++;
            $display("FAIL rst_refill: got %0d words want %0d", out_cnt - c0, N * DIGITS);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_neg_lift();
        test_ping_pong();
        test_backpressure();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
